// File: rtl/csr_trap_ctrl_pkg.sv
// Shared constants and type definitions for the machine-mode trap sequencer.
// CSR addresses, mstatus bit positions, the external-interrupt cause and state encodings.
package csr_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [31:0] CAUSE_MEXT_INT = 32'h8000_000B;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SAVE_EPC    = 3'd1,
    ST_SAVE_CAUSE  = 3'd2,
    ST_SAVE_STATUS = 3'd3,
    ST_MRET_STATUS = 3'd4,
    ST_JUMP        = 3'd5
  } trap_state_e;

  typedef enum logic [1:0] {
    KIND_EXC  = 2'd0,
    KIND_INT  = 2'd1,
    KIND_MRET = 2'd2
  } trap_kind_e;

endpackage

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap sequencer: saves mepc/mcause/mstatus through the shared CSR
// write port, then redirects fetch; execute's CSR writes pass through when idle.
module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int CSR_ADDR_W  = 12,
  parameter int VECTORED_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exc_req_i,
  input  logic [DATA_W-1:0]     exc_cause_i,
  input  logic [DATA_W-1:0]     exc_pc_i,
  input  logic                  mret_req_i,
  input  logic                  int_req_i,
  input  logic [DATA_W-1:0]     int_pc_i,
  input  logic [DATA_W-1:0]     mstatus_i,
  input  logic [DATA_W-1:0]     mtvec_i,
  input  logic [DATA_W-1:0]     mepc_i,
  input  logic                  ex_csr_we_i,
  input  logic [CSR_ADDR_W-1:0] ex_csr_waddr_i,
  input  logic [DATA_W-1:0]     ex_csr_wdata_i,
  output logic                  csr_we_o,
  output logic [CSR_ADDR_W-1:0] csr_waddr_o,
  output logic [DATA_W-1:0]     csr_wdata_o,
  output logic                  hold_o,
  output logic                  jump_o,
  output logic [DATA_W-1:0]     jump_addr_o
);

  trap_state_e       state_r;
  trap_state_e       state_nx_s;
  trap_kind_e        kind_r;
  logic [DATA_W-1:0] epc_r;
  logic [DATA_W-1:0] cause_r;

  logic idle_s;
  logic take_exc_s;
  logic take_mret_s;
  logic take_int_s;
  logic accept_s;
  logic unused_s;

  function automatic logic [DATA_W-1:0] trap_mstatus(input logic [DATA_W-1:0] cur);
    logic [DATA_W-1:0] nxt;
    nxt                                 = cur;
    nxt[MSTATUS_MPIE]                   = cur[MSTATUS_MIE];
    nxt[MSTATUS_MIE]                    = 1'b0;
    nxt[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
    return nxt;
  endfunction

  function automatic logic [DATA_W-1:0] mret_mstatus(input logic [DATA_W-1:0] cur);
    logic [DATA_W-1:0] nxt;
    nxt                                 = cur;
    nxt[MSTATUS_MIE]                    = cur[MSTATUS_MPIE];
    nxt[MSTATUS_MPIE]                   = 1'b1;
    nxt[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
    return nxt;
  endfunction

  // Vectored mode applies only to interrupts; bit 30 of the cause shifts out of range.
  function automatic logic [DATA_W-1:0] trap_target(input logic [DATA_W-1:0] tvec,
                                                     input logic [DATA_W-1:0] cause,
                                                     input logic              is_int);
    logic [DATA_W-1:0] base;
    base = {tvec[DATA_W-1:2], 2'b00};
    if ((VECTORED_EN != 0) && is_int && (tvec[1:0] == 2'b01)) begin
      return base + {cause[DATA_W-3:0], 2'b00};
    end else begin
      return base;
    end
  endfunction

  assign idle_s      = (state_r == ST_IDLE) && !rst;
  assign take_exc_s  = idle_s && exc_req_i;
  assign take_mret_s = idle_s && !exc_req_i && mret_req_i;
  assign take_int_s  = idle_s && !exc_req_i && !mret_req_i && int_req_i && mstatus_i[MSTATUS_MIE];
  assign accept_s    = take_exc_s || take_mret_s || take_int_s;

  assign unused_s = ^{exc_pc_i[1:0], int_pc_i[1:0], epc_r[1:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Trap context captured at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      kind_r  <= KIND_EXC;
      epc_r   <= '0;
      cause_r <= '0;
    end else if (take_exc_s) begin
      kind_r  <= KIND_EXC;
      epc_r   <= exc_pc_i;
      cause_r <= exc_cause_i;
    end else if (take_int_s) begin
      kind_r  <= KIND_INT;
      epc_r   <= int_pc_i;
      cause_r <= DATA_W'(CAUSE_MEXT_INT);
    end else if (take_mret_s) begin
      kind_r  <= KIND_MRET;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (take_exc_s || take_int_s) begin
          state_nx_s = ST_SAVE_EPC;
        end else if (take_mret_s) begin
          state_nx_s = ST_MRET_STATUS;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SAVE_EPC:    state_nx_s = ST_SAVE_CAUSE;
      ST_SAVE_CAUSE:  state_nx_s = ST_SAVE_STATUS;
      ST_SAVE_STATUS: state_nx_s = ST_JUMP;
      ST_MRET_STATUS: state_nx_s = ST_JUMP;
      ST_JUMP:        state_nx_s = ST_IDLE;
      default:        state_nx_s = ST_IDLE;
    endcase
  end

  // Output logic; while in reset the controller drives nothing of its own.
  always_comb begin
    csr_we_o    = ex_csr_we_i;
    csr_waddr_o = ex_csr_waddr_i;
    csr_wdata_o = ex_csr_wdata_i;
    hold_o      = 1'b0;
    jump_o      = 1'b0;
    jump_addr_o = '0;
    if (rst) begin
      hold_o = 1'b0;
    end else begin
      hold_o = (state_r != ST_IDLE) || accept_s;
      case (state_r)
        ST_SAVE_EPC: begin
          csr_we_o    = 1'b1;
          csr_waddr_o = CSR_ADDR_W'(CSR_MEPC);
          csr_wdata_o = {epc_r[DATA_W-1:2], 2'b00};
        end
        ST_SAVE_CAUSE: begin
          csr_we_o    = 1'b1;
          csr_waddr_o = CSR_ADDR_W'(CSR_MCAUSE);
          csr_wdata_o = cause_r;
        end
        ST_SAVE_STATUS: begin
          csr_we_o    = 1'b1;
          csr_waddr_o = CSR_ADDR_W'(CSR_MSTATUS);
          csr_wdata_o = trap_mstatus(mstatus_i);
        end
        ST_MRET_STATUS: begin
          csr_we_o    = 1'b1;
          csr_waddr_o = CSR_ADDR_W'(CSR_MSTATUS);
          csr_wdata_o = mret_mstatus(mstatus_i);
        end
        ST_JUMP: begin
          jump_o = 1'b1;
          if (kind_r == KIND_MRET) begin
            jump_addr_o = mepc_i;
          end else begin
            jump_addr_o = trap_target(mtvec_i, cause_r, kind_r == KIND_INT);
          end
        end
        default: begin
          jump_o = 1'b0;
        end
      endcase
    end
  end

endmodule
